// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register
// offsets, STATUS bit positions, transmitter state encoding and the
// word-aligned address compare used by the register decode.
package mmio_uart_pkg;

  localparam logic [31:0] REG_DATA_OFS   = 32'd0;
  localparam logic [31:0] REG_STATUS_OFS = 32'd4;

  localparam int STATUS_FULL_BIT = 0;
  localparam int STATUS_IDLE_BIT = 1;
  localparam int STATUS_OVF_BIT  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Byte lanes inside a word are not decoded: compare word addresses only.
  function automatic logic word_hit(input logic [31:0] addr, input logic [31:0] target);
    return addr[31:2] == target[31:2];
  endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers: equal pointers mean empty,
// pointers differing only in the MSB mean full. A push while full is
// accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en_s, rd_en_s;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr_en_s = push_i && (!full_o || pop_i);
  assign rd_en_s = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance on accepted push / pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en_s) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; cleared on reset so no stale byte is ever observable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped console transmitter. Stores to DATA are queued in a FIFO
// and sent 8N1, LSB first, on uart_txd. STATUS reports {ovf, idle, full}.
// Build option: UART_TX_SIM_PRINT_EN echoes accepted bytes with $write and
// warns on overrun (simulation only); undefined builds are pure RTL.
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1FD0_03F8,
  parameter int          CLK_DIV    = 16,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_we,
  input  logic        mem_re,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        uart_txd,
  output logic        tx_busy
);

  localparam int          BW          = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [31:0] DATA_ADDR   = BASE_ADDR + REG_DATA_OFS;
  localparam logic [31:0] STATUS_ADDR = BASE_ADDR + REG_STATUS_OFS;

  tx_state_t   state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        txd_q, txd_d;
  logic        ovf_q, ovf_d;

  logic        push_req_s, push_ok_s, ovf_set_s, status_rd_s, pop_s, baud_wrap_s;
  logic        fifo_full_s, fifo_empty_s;
  logic [7:0]  fifo_rdata_s;
  logic [31:0] status_s;
  logic        unused_s;

  assign unused_s    = ^mem_wdata[31:8];
  assign push_req_s  = mem_we && word_hit(mem_addr, DATA_ADDR);
  assign status_rd_s = mem_re && word_hit(mem_addr, STATUS_ADDR);
  assign push_ok_s   = push_req_s && (!fifo_full_s || pop_s);
  assign ovf_set_s   = push_req_s && fifo_full_s && !pop_s;
  assign baud_wrap_s = (baud_q == BW'(CLK_DIV - 1));

  assign uart_txd = txd_q;
  assign tx_busy  = (state_q != IDLE) || !fifo_empty_s;

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (rst),
    .push_i (push_ok_s),
    .pop_i  (pop_s),
    .wdata_i(mem_wdata[7:0]),
    .rdata_o(fifo_rdata_s),
    .full_o (fifo_full_s),
    .empty_o(fifo_empty_s)
  );

  // Frame sequencer: baud count, bit count, shift register and line level.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_wrap_s ? '0 : baud_q + BW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    pop_s   = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          shift_d = fifo_rdata_s;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (baud_wrap_s) begin
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (baud_wrap_s) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          state_d = (bit_q == 3'd7) ? STOP : DATA;
        end else begin
          state_d = DATA;
        end
      end
      STOP: begin
        if (baud_wrap_s && !fifo_empty_s) begin
          pop_s   = 1'b1;
          shift_d = fifo_rdata_s;
          state_d = START;
        end else if (baud_wrap_s) begin
          state_d = IDLE;
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        baud_d  = '0;
        state_d = IDLE;
      end
    endcase

    case (state_q)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_q[0];
      default: txd_d = 1'b1;
    endcase
  end

  // Sticky overrun flag: set has priority over the clear-on-STATUS-read.
  always_comb begin
    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else if (status_rd_s) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // STATUS read mux; every other load returns zero.
  always_comb begin
    status_s                  = 32'd0;
    status_s[STATUS_OVF_BIT]  = ovf_q;
    status_s[STATUS_IDLE_BIT] = fifo_empty_s && (state_q == IDLE);
    status_s[STATUS_FULL_BIT] = fifo_full_s;
    if (status_rd_s) begin
      mem_rdata = status_s;
    end else begin
      mem_rdata = 32'd0;
    end
  end

  // Transmitter state registers; the line idles high through reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      txd_q   <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef UART_TX_SIM_PRINT_EN
  // Simulation console echo of accepted bytes and overrun warnings.
  always_ff @(posedge clk) begin
    if (rst && push_ok_s) begin
      $write("%c", mem_wdata[7:0]);
    end
    if (rst && ovf_set_s) begin
      $display("mmio_uart_tx: warning: TX FIFO overrun, byte dropped");
    end
  end
`else
  // No console echo in hardware builds.
`endif

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx (CLK_DIV=4, FIFO_DEPTH=4).
// A frame-position reference model predicts line level and STATUS; an
// independent UART receiver decodes the line for byte-level checks.
module tb_mmio_uart_tx;

  localparam int          D      = 4;
  localparam int          DEPTH  = 4;
  localparam int          FRAME  = 10 * D;
  localparam logic [31:0] DATA_A = 32'h1FD0_03F8;
  localparam logic [31:0] STAT_A = 32'h1FD0_03FC;

  logic        clk = 1'b0;
  logic        rst, mem_we, mem_re;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        uart_txd, tx_busy;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  mmio_uart_tx #(.BASE_ADDR(DATA_A), .CLK_DIV(D), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .uart_txd(uart_txd), .tx_busy(tx_busy)
  );

  // ---------------- reference model: queue + position within current frame
  logic [7:0] m_q[$];
  logic [7:0] m_log[$];
  logic       m_busy, m_ovf, m_txd;
  int         m_pos;
  logic [7:0] m_cur;

  always @(posedge clk or negedge rst) begin : model
    int sz, idx;
    logic pop_m, push_m, stat_m, fb;
    logic [7:0] nb;
    if (!rst) begin
      m_q.delete();
      m_busy <= 1'b0; m_ovf <= 1'b0; m_txd <= 1'b1; m_pos <= 0; m_cur <= 8'd0;
    end else begin
      sz     = m_q.size();
      pop_m  = (sz > 0) && (!m_busy || m_pos == FRAME - 1);
      push_m = mem_we && (mem_addr[31:2] == DATA_A[31:2]);
      stat_m = mem_re && (mem_addr[31:2] == STAT_A[31:2]);
      idx    = m_pos / D;
      if (!m_busy) fb = 1'b1;
      else if (idx == 0) fb = 1'b0;
      else if (idx <= 8) fb = m_cur[idx-1];
      else fb = 1'b1;
      m_txd <= fb;
      if (pop_m) begin
        nb = m_q.pop_front();
        m_cur <= nb; m_busy <= 1'b1; m_pos <= 0;
      end else if (m_busy) begin
        if (m_pos == FRAME - 1) m_busy <= 1'b0;
        else m_pos <= m_pos + 1;
      end
      if (push_m && (sz < DEPTH || pop_m)) begin
        m_q.push_back(mem_wdata[7:0]);
        m_log.push_back(mem_wdata[7:0]);
      end
      if (push_m && sz == DEPTH && !pop_m) m_ovf <= 1'b1;
      else if (stat_m) m_ovf <= 1'b0;
    end
  end

  function automatic logic [31:0] exp_status();
    return {29'd0, m_ovf, ((m_q.size() == 0) && !m_busy), (m_q.size() == DEPTH)};
  endfunction

  function automatic logic exp_busy();
    return m_busy || (m_q.size() > 0);
  endfunction

  // ---------------- independent line receiver (mid-bit sampling)
  logic [7:0] rx_q[$];
  logic [7:0] rx_b;
  logic       rx_on;
  int         rx_t;

  always @(negedge clk or negedge rst) begin : uart_rx
    if (!rst) begin
      rx_on <= 1'b0; rx_t <= 0;
    end else if (!rx_on) begin
      if (uart_txd === 1'b0) begin rx_on <= 1'b1; rx_t <= 1; end
    end else begin
      if ((rx_t % D) == (D / 2) && rx_t >= D && rx_t < 9 * D) rx_b[rx_t/D - 1] <= uart_txd;
      if (rx_t == 9 * D + D / 2) rx_q.push_back(rx_b);
      if (rx_t == FRAME - 1) rx_on <= 1'b0;
      else rx_t <= rx_t + 1;
    end
  end

  task automatic idle_inputs();
    mem_we = 1'b0; mem_re = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0;
  endtask

  task automatic store(input logic [7:0] b);
    mem_we = 1'b1; mem_addr = DATA_A; mem_wdata = {24'd0, b};
  endtask

  // ---------------- scenarios
  task automatic test_reset();
    rst = 1'b0; idle_inputs();
    repeat (3) @(negedge clk);
    checks++; if (uart_txd !== 1'b1) begin failures++; $display("FAIL reset_txd got=%b exp=1", uart_txd); end
    checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", tx_busy); end
    mem_re = 1'b1; mem_addr = STAT_A; #1;
    checks++; if (mem_rdata !== 32'h2) begin failures++; $display("FAIL reset_status got=%h exp=00000002", mem_rdata); end
    idle_inputs(); #1 rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++; if (uart_txd !== 1'b1) begin failures++; $display("FAIL reset_release_txd k=%0d got=%b exp=1", k, uart_txd); end
    end
  endtask

  task automatic test_single();
    int first_low = -1;
    int busy_fall = -1;
    rx_q.delete();
    store(8'hA5);
    @(negedge clk);
    idle_inputs();
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      checks++; if (uart_txd !== m_txd) begin failures++; $display("FAIL single_txd k=%0d got=%b exp=%b", k, uart_txd, m_txd); end
      checks++; if (tx_busy !== exp_busy()) begin failures++; $display("FAIL single_busy k=%0d got=%b exp=%b", k, tx_busy, exp_busy()); end
      if (first_low < 0 && uart_txd === 1'b0) first_low = k;
      if (busy_fall < 0 && tx_busy === 1'b0) busy_fall = k;
    end
    checks++; if (first_low != 2) begin failures++; $display("FAIL single_latency got=%0d exp=2", first_low); end
    checks++; if (busy_fall != 41) begin failures++; $display("FAIL single_busy_fall got=%0d exp=41", busy_fall); end
    checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
      failures++; $display("FAIL single_rx got_n=%0d exp_n=1 exp_byte=a5", rx_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int busy_fall = -1;
    logic txd42 = 1'b1;
    rx_q.delete();
    store(8'h41);
    @(negedge clk);
    store(8'h42);
    for (int k = 1; k <= 90; k++) begin
      @(negedge clk);
      idle_inputs();
      checks++; if (uart_txd !== m_txd) begin failures++; $display("FAIL b2b_txd k=%0d got=%b exp=%b", k, uart_txd, m_txd); end
      if (k == 42) txd42 = uart_txd;
      if (busy_fall < 0 && tx_busy === 1'b0) busy_fall = k;
    end
    checks++; if (txd42 !== 1'b0) begin failures++; $display("FAIL b2b_no_gap got=%b exp=0", txd42); end
    checks++; if (busy_fall != 81) begin failures++; $display("FAIL b2b_busy_fall got=%0d exp=81", busy_fall); end
    checks++; if (rx_q.size() != 2 || rx_q[0] !== 8'h41 || rx_q[1] !== 8'h42) begin
      failures++; $display("FAIL b2b_rx got_n=%0d exp_n=2 exp=41,42", rx_q.size());
    end
  endtask

  task automatic test_overflow();
    logic [7:0] b[6];
    logic done = 1'b0;
    rx_q.delete();
    for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) begin store(b[i]); @(negedge clk); end
    idle_inputs(); mem_re = 1'b1; mem_addr = STAT_A; #1;
    checks++; if (mem_rdata !== 32'h5) begin failures++; $display("FAIL ovf_status1 got=%h exp=00000005", mem_rdata); end
    checks++; if (mem_rdata !== exp_status()) begin failures++; $display("FAIL ovf_status1_model got=%h exp=%h", mem_rdata, exp_status()); end
    @(negedge clk); #1;
    checks++; if (mem_rdata !== 32'h1) begin failures++; $display("FAIL ovf_status2 got=%h exp=00000001", mem_rdata); end
    @(negedge clk); #1;
    checks++; if (mem_rdata !== 32'h1) begin failures++; $display("FAIL ovf_status3 got=%h exp=00000001", mem_rdata); end
    idle_inputs();
    for (int k = 0; k < 600 && !done; k++) begin
      @(negedge clk);
      checks++; if (uart_txd !== m_txd) begin failures++; $display("FAIL ovf_txd k=%0d got=%b exp=%b", k, uart_txd, m_txd); end
      if (tx_busy === 1'b0) done = 1'b1;
    end
    checks++; if (!done) begin failures++; $display("FAIL ovf_drain got=busy exp=idle"); end
    repeat (2) @(negedge clk);
    checks++; if (rx_q.size() != 5) begin failures++; $display("FAIL ovf_rx_count got=%0d exp=5", rx_q.size()); end
    for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== b[i]) begin failures++; $display("FAIL ovf_rx_byte i=%0d got=%h exp=%h", i, rx_q[i], b[i]); end
    end
  endtask

  task automatic test_full_pop();
    logic [7:0] b[6];
    logic done = 1'b0;
    rx_q.delete();
    for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
    for (int i = 0; i < 5; i++) begin store(b[i]); @(negedge clk); end
    idle_inputs();
    for (int k = 5; k <= 39; k++) begin
      @(negedge clk);
      checks++; if (uart_txd !== m_txd) begin failures++; $display("FAIL fullpop_txd k=%0d got=%b exp=%b", k, uart_txd, m_txd); end
    end
    mem_re = 1'b1; mem_addr = STAT_A; #1;
    checks++; if (mem_rdata !== 32'h1) begin failures++; $display("FAIL fullpop_pre got=%h exp=00000001", mem_rdata); end
    @(negedge clk);
    idle_inputs(); store(b[5]);
    @(negedge clk);
    idle_inputs(); mem_re = 1'b1; mem_addr = STAT_A; #1;
    checks++; if (mem_rdata !== 32'h1) begin failures++; $display("FAIL fullpop_post got=%h exp=00000001", mem_rdata); end
    checks++; if (mem_rdata !== exp_status()) begin failures++; $display("FAIL fullpop_model got=%h exp=%h", mem_rdata, exp_status()); end
    idle_inputs();
    for (int k = 0; k < 600 && !done; k++) begin
      @(negedge clk);
      checks++; if (uart_txd !== m_txd) begin failures++; $display("FAIL fullpop_drain_txd k=%0d got=%b exp=%b", k, uart_txd, m_txd); end
      if (tx_busy === 1'b0) done = 1'b1;
    end
    checks++; if (!done) begin failures++; $display("FAIL fullpop_drain got=busy exp=idle"); end
    repeat (2) @(negedge clk);
    checks++; if (rx_q.size() != 6) begin failures++; $display("FAIL fullpop_rx_count got=%0d exp=6", rx_q.size()); end
    for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== b[i]) begin failures++; $display("FAIL fullpop_rx_byte i=%0d got=%h exp=%h", i, rx_q[i], b[i]); end
    end
  endtask

  task automatic test_random();
    int acc0, r;
    logic [31:0] exp_rd;
    logic done = 1'b0;
    rx_q.delete();
    acc0 = m_log.size();
    for (int i = 0; i < 500; i++) begin
      idle_inputs();
      r = int'($urandom_range(0, 9));
      if (r < 2) begin
        mem_we = 1'b1; mem_addr = DATA_A + 32'($urandom_range(0, 3)); mem_wdata = $urandom;
      end else if (r == 2) begin
        mem_we = 1'b1; mem_addr = DATA_A + 32'd8; mem_wdata = $urandom;
      end
      if ($urandom_range(0, 3) == 0) begin
        mem_re = 1'b1;
        mem_addr = ($urandom_range(0, 1) == 1) ? STAT_A + 32'($urandom_range(0, 3)) : DATA_A;
      end
      #1;
      exp_rd = (mem_re && (mem_addr[31:2] == STAT_A[31:2])) ? exp_status() : 32'd0;
      checks++; if (mem_rdata !== exp_rd) begin failures++; $display("FAIL rand_rdata i=%0d got=%h exp=%h", i, mem_rdata, exp_rd); end
      @(negedge clk);
      checks++; if (uart_txd !== m_txd) begin failures++; $display("FAIL rand_txd i=%0d got=%b exp=%b", i, uart_txd, m_txd); end
      checks++; if (tx_busy !== exp_busy()) begin failures++; $display("FAIL rand_busy i=%0d got=%b exp=%b", i, tx_busy, exp_busy()); end
    end
    idle_inputs();
    for (int k = 0; k < 1000 && !done; k++) begin
      @(negedge clk);
      checks++; if (uart_txd !== m_txd) begin failures++; $display("FAIL rand_drain_txd k=%0d got=%b exp=%b", k, uart_txd, m_txd); end
      if (tx_busy === 1'b0) done = 1'b1;
    end
    checks++; if (!done) begin failures++; $display("FAIL rand_drain got=busy exp=idle"); end
    repeat (2) @(negedge clk);
    checks++; if (rx_q.size() != m_log.size() - acc0) begin
      failures++; $display("FAIL rand_rx_count got=%0d exp=%0d", rx_q.size(), m_log.size() - acc0);
    end
    for (int i = 0; i < rx_q.size() && acc0 + i < m_log.size(); i++) begin
      checks++; if (rx_q[i] !== m_log[acc0+i]) begin failures++; $display("FAIL rand_rx_byte i=%0d got=%h exp=%h", i, rx_q[i], m_log[acc0+i]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    rx_q.delete();
    store(8'h00);
    @(negedge clk);
    idle_inputs();
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      checks++; if (uart_txd !== m_txd) begin failures++; $display("FAIL midrst_txd k=%0d got=%b exp=%b", k, uart_txd, m_txd); end
    end
    #2 rst = 1'b0;
    #1;
    checks++; if (uart_txd !== 1'b1) begin failures++; $display("FAIL midrst_txd_async got=%b exp=1", uart_txd); end
    checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", tx_busy); end
    @(negedge clk);
    #2 rst = 1'b1;
    mem_re = 1'b1; mem_addr = STAT_A; #1;
    checks++; if (mem_rdata !== 32'h2) begin failures++; $display("FAIL midrst_status got=%h exp=00000002", mem_rdata); end
    idle_inputs();
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      checks++; if (uart_txd !== 1'b1) begin failures++; $display("FAIL midrst_residual k=%0d got=%b exp=1", k, uart_txd); end
    end
    checks++; if (rx_q.size() != 0) begin failures++; $display("FAIL midrst_rx got=%0d exp=0", rx_q.size()); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_random();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
